// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-file hazard controller between decode and writeback.
// Keeps one pending-write counter per register code and holds decode while a
// source has an outstanding write or the destination counter is full.
// Optional feature macro: HAZ_WB_BYPASS_EN (same-cycle writeback forwarding
// suppresses a source hazard on the last pending write).
//
// Issue handshake: decode raises issue_vld_in with its operands. The
// instruction is accepted in that same cycle exactly when issue_ack_out=1;
// when stall_out=1 decode must hold the same instruction and retry. Both
// outputs are combinational and both are 0 whenever issue_vld_in=0.
// Writeback is a one-way strobe (wb_vld_in) with no back-pressure.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int PEND_MAX = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_vld_in,
  input  logic             rs_a_en_in,
  input  logic [3:0]       rs_a_in,
  input  logic             rs_b_en_in,
  input  logic [3:0]       rs_b_in,
  input  logic             rd_en_in,
  input  logic [3:0]       rd_in,
  input  logic             wb_vld_in,
  input  logic [3:0]       wb_reg_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             issue_ack_out,
  output logic             busy_out,
  output logic             err_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam int            PW       = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  // Constant registers are never written, so they never carry a hazard.
  localparam logic [3:0] ZERO_REG = 4'd14;
  localparam logic [3:0] ONE_REG  = 4'd15;

  function automatic logic is_tracked(input logic [3:0] r);
    return (r != ZERO_REG) && (r != ONE_REG);
  endfunction

  logic [PW-1:0] pend_q [NUM_REGS];
  logic [PW-1:0] pend_d [NUM_REGS];
  logic [PW-1:0] pend_a, pend_b, pend_rd, pend_wb;
  logic          byp_a, byp_b;
  logic          haz_a, haz_b, full;
  logic          busy_d;
  logic          err_set;

  assign pend_a  = pend_q[rs_a_in];
  assign pend_b  = pend_q[rs_b_in];
  assign pend_rd = pend_q[rd_in];
  assign pend_wb = pend_q[wb_reg_in];

`ifdef HAZ_WB_BYPASS_EN
  // The retiring write is forwarded by the register file write-through, so a
  // source whose only pending write retires this cycle needs no stall.
  assign byp_a = wb_vld_in && (wb_reg_in == rs_a_in) && (pend_a == PEND_ONE);
  assign byp_b = wb_vld_in && (wb_reg_in == rs_b_in) && (pend_b == PEND_ONE);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // Hazard detection and same-cycle accept/stall decision.
  always_comb begin
    haz_a         = rs_a_en_in && is_tracked(rs_a_in) && (pend_a != '0) && !byp_a;
    haz_b         = rs_b_en_in && is_tracked(rs_b_in) && (pend_b != '0) && !byp_b;
    full          = rd_en_in && is_tracked(rd_in) && (pend_rd == PEND_TOP);
    stall_out     = issue_vld_in && (flush_in || haz_a || haz_b || full);
    issue_ack_out = issue_vld_in && !stall_out;
    err_set       = !flush_in && wb_vld_in && is_tracked(wb_reg_in) && (pend_wb == '0);
  end

  // Next pending count per register: flush clears, issue adds, writeback retires.
  always_comb begin : next_pend
    logic inc;
    logic dec;
    busy_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = issue_ack_out && rd_en_in && (rd_in == 4'(r)) && is_tracked(rd_in);
      dec = wb_vld_in && (wb_reg_in == 4'(r)) && is_tracked(wb_reg_in) &&
            (pend_q[r] != '0);
      pend_d[r] = pend_q[r];
      if (flush_in) begin
        pend_d[r] = '0;
      end else if (inc && !dec) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec && !inc) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
      busy_d = busy_d | (pend_d[r] != '0);
    end
  end

  // Pending-write counter array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  // Registered busy flag and sticky writeback-underflow error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      busy_out <= busy_d;
      if (err_set) begin
        err_out <= 1'b1;
      end
    end
  end

  // Saturating count of stalled issue cycles; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_out <= '0;
    end else if (stall_out && (stall_cnt_out != '1)) begin
      stall_cnt_out <= stall_cnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: vector table applied cycle by cycle with a
// scoreboard queue, then hand-written reset-mid-run and bypass sequences.
module tb_reg_scoreboard;

  localparam int CNT_W = 16;
  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R1 = 4'd1;
  localparam logic [3:0] R2 = 4'd2;
  localparam logic [3:0] R3 = 4'd3;
  localparam logic [3:0] RZ = 4'd14;
  localparam logic [3:0] RO = 4'd15;
`ifdef HAZ_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_vld_in, rs_a_en_in, rs_b_en_in, rd_en_in, wb_vld_in, flush_in;
  logic [3:0]       rs_a_in, rs_b_in, rd_in, wb_reg_in;
  logic             stall_out, issue_ack_out, busy_out, err_out;
  logic [CNT_W-1:0] stall_cnt_out;

  typedef struct {
    logic       vld;
    logic       a_en;
    logic [3:0] a;
    logic       b_en;
    logic [3:0] b;
    logic       rd_en;
    logic [3:0] rd;
    logic       wb;
    logic [3:0] wbr;
    logic       fl;
    logic       es;   // expected stall_out
    logic       ea;   // expected issue_ack_out
    logic       eb;   // expected busy_out after the edge
    logic       ee;   // expected err_out after the edge
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         exp_cnt = 0;
  logic [3:0] exp_q[$];
  vec_t       tbl[36];
  vec_t       v;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_vld_in(issue_vld_in), .rs_a_en_in(rs_a_en_in), .rs_a_in(rs_a_in),
    .rs_b_en_in(rs_b_en_in), .rs_b_in(rs_b_in), .rd_en_in(rd_en_in), .rd_in(rd_in),
    .wb_vld_in(wb_vld_in), .wb_reg_in(wb_reg_in), .flush_in(flush_in),
    .stall_out(stall_out), .issue_ack_out(issue_ack_out), .busy_out(busy_out),
    .err_out(err_out), .stall_cnt_out(stall_cnt_out)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vld, input logic a_en, input logic [3:0] a,
                              input logic b_en, input logic [3:0] b,
                              input logic rd_en, input logic [3:0] rd,
                              input logic wb, input logic [3:0] wbr, input logic fl,
                              input logic es, input logic ea, input logic eb,
                              input logic ee);
    vec_t r;
    r.vld = vld; r.a_en = a_en; r.a = a; r.b_en = b_en; r.b = b;
    r.rd_en = rd_en; r.rd = rd; r.wb = wb; r.wbr = wbr; r.fl = fl;
    r.es = es; r.ea = ea; r.eb = eb; r.ee = ee;
    return r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", nm, id, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input vec_t d);
    issue_vld_in = d.vld; rs_a_en_in = d.a_en; rs_a_in = d.a;
    rs_b_en_in = d.b_en; rs_b_in = d.b; rd_en_in = d.rd_en; rd_in = d.rd;
    wb_vld_in = d.wb; wb_reg_in = d.wbr; flush_in = d.fl;
  endtask

  // One cycle: drive, score combinational outputs, then registered outputs.
  task automatic apply(input vec_t d, input int id);
    logic [3:0] e;
    @(negedge clk);
    drive(d);
    exp_q.push_back({d.es, d.ea, d.eb, d.ee});
    #2;
    e = exp_q.pop_front();
    chk("stall", id, 32'(stall_out), 32'(e[3]));
    chk("ack", id, 32'(issue_ack_out), 32'(e[2]));
    if (e[3]) exp_cnt++;
    @(posedge clk);
    #1;
    chk("busy", id, 32'(busy_out), 32'(e[1]));
    chk("err", id, 32'(err_out), 32'(e[0]));
    chk("stall_cnt", id, 32'(stall_cnt_out), 32'(exp_cnt));
  endtask

  initial begin
    // Issue/retire/stall table from reset; pend noted as reg=count after edge.
    tbl[0]  = mk(0,0,R0,0,R0,0,R0,0,R0,0, 0,0,0,0);  // idle
    tbl[1]  = mk(1,0,R0,0,R0,1,R2,0,R0,0, 0,1,1,0);  // R2=1
    tbl[2]  = mk(1,1,R2,0,R0,0,R0,0,R0,0, 1,0,1,0);  // RAW stall
    tbl[3]  = mk(1,1,R2,0,R0,0,R0,0,R0,0, 1,0,1,0);
    tbl[4]  = mk(1,1,R2,0,R0,0,R0,0,R0,0, 1,0,1,0);
    tbl[5]  = mk(0,0,R0,0,R0,0,R0,1,R2,0, 0,0,0,0);  // wb R2 -> 0
    tbl[6]  = mk(1,1,R2,0,R0,0,R0,0,R0,0, 0,1,0,0);  // now acked
    tbl[7]  = mk(1,0,R0,0,R0,1,R3,0,R0,0, 0,1,1,0);  // R3=1
    tbl[8]  = mk(1,0,R0,0,R0,1,R3,0,R0,0, 0,1,1,0);  // R3=2
    tbl[9]  = mk(1,0,R0,0,R0,1,R3,0,R0,0, 0,1,1,0);  // R3=3
    tbl[10] = mk(1,0,R0,0,R0,1,R3,0,R0,0, 1,0,1,0);  // full
    tbl[11] = mk(1,0,R0,0,R0,1,R3,1,R3,0, 1,0,1,0);  // full not bypassed, R3=2
    tbl[12] = mk(1,0,R0,0,R0,1,R3,0,R0,0, 0,1,1,0);  // R3=3
    tbl[13] = mk(1,0,R0,1,R3,0,R0,0,R0,0, 1,0,1,0);  // rs_b hazard
    tbl[14] = mk(1,0,R3,0,R3,0,R0,0,R0,0, 0,1,1,0);  // disabled sources
    tbl[15] = mk(1,0,R0,0,R0,0,R3,0,R0,0, 0,1,1,0);  // rd_en=0 ignores full
    tbl[16] = mk(1,0,R0,0,R0,1,RZ,0,R0,0, 0,1,1,0);  // write ZERO not counted
    tbl[17] = mk(1,1,RZ,1,RO,0,R0,0,R0,0, 0,1,1,0);  // read ZERO/ONE
    tbl[18] = mk(0,0,R0,0,R0,0,R0,1,RZ,0, 0,0,1,0);  // wb ZERO no err
    tbl[19] = mk(0,0,R0,0,R0,0,R0,1,R3,0, 0,0,1,0);  // R3=2
    tbl[20] = mk(0,0,R0,0,R0,0,R0,1,R3,0, 0,0,1,0);  // R3=1
    tbl[21] = mk(0,0,R0,0,R0,0,R0,1,R3,0, 0,0,0,0);  // R3=0
    tbl[22] = mk(1,0,R0,0,R0,1,R0,0,R0,0, 0,1,1,0);  // R0=1
    tbl[23] = mk(1,0,R0,0,R0,1,R0,1,R0,0, 0,1,1,0);  // inc&dec, R0=1
    tbl[24] = mk(0,0,R0,0,R0,0,R0,1,R0,0, 0,0,0,0);  // R0=0
    tbl[25] = mk(0,0,R0,0,R0,0,R0,1,R3,0, 0,0,0,1);  // underflow err
    tbl[26] = mk(0,0,R0,0,R0,0,R0,0,R0,0, 0,0,0,1);  // err sticky
    tbl[27] = mk(0,0,R0,0,R0,0,R0,1,RO,0, 0,0,0,1);
    tbl[28] = mk(1,1,R1,0,R0,1,R1,0,R0,0, 0,1,1,1);  // src==dst, R1=1
    tbl[29] = mk(0,0,R0,0,R0,0,R0,1,R1,0, 0,0,0,1);  // R1=0
    tbl[30] = mk(1,0,R0,0,R0,1,R0,0,R0,0, 0,1,1,1);  // R0=1
    tbl[31] = mk(1,0,R0,0,R0,1,R0,0,R0,0, 0,1,1,1);  // R0=2
    tbl[32] = mk(1,0,R0,0,R0,1,R2,0,R0,0, 0,1,1,1);  // R2=1
    tbl[33] = mk(1,0,R0,0,R0,1,R1,0,R0,1, 1,0,0,1);  // flush
    tbl[34] = mk(1,1,RZ,0,R0,0,R0,0,R0,0, 0,1,0,1);
    tbl[35] = mk(1,1,R0,1,R2,0,R0,0,R0,0, 0,1,0,1);  // cleared by flush

    drive(mk(0,0,R0,0,R0,0,R0,0,R0,0, 0,0,0,0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", -1, 32'(busy_out), 32'd0);
    chk("rst_err", -1, 32'(err_out), 32'd0);
    chk("rst_cnt", -1, 32'(stall_cnt_out), 32'd0);
    chk("rst_stall", -1, 32'(stall_out), 32'd0);
    chk("rst_ack", -1, 32'(issue_ack_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i], i);
    end

    // Asynchronous reset mid-run with R1=2, err set, stall count nonzero.
    apply(mk(1,0,R0,0,R0,1,R1,0,R0,0, 0,1,1,1), 100);
    apply(mk(1,0,R0,0,R0,1,R1,0,R0,0, 0,1,1,1), 101);
    @(negedge clk);
    drive(mk(0,0,R0,0,R0,0,R0,0,R0,0, 0,0,0,0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 102, 32'(busy_out), 32'd0);
    chk("mid_rst_err", 102, 32'(err_out), 32'd0);
    chk("mid_rst_cnt", 102, 32'(stall_cnt_out), 32'd0);
    chk("mid_rst_stall", 102, 32'(stall_out), 32'd0);
    chk("mid_rst_ack", 102, 32'(issue_ack_out), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1,1,R1,0,R0,0,R0,0,R0,0, 0,1,0,0), 103);

    // Same-cycle writeback of the last pending write against a source read.
    apply(mk(1,0,R0,0,R0,1,R1,0,R0,0, 0,1,1,0), 110);           // R1=1
    v = mk(1,1,R1,0,R0,0,R0,1,R1,0, 0,0,0,0);
    v.es = ~BYP;
    v.ea = BYP;
    apply(v, 111);                                              // R1=0
    apply(mk(1,1,R1,0,R0,0,R0,0,R0,0, 0,1,0,0), 112);

    // Writeback with two pending never forwards.
    apply(mk(1,0,R0,0,R0,1,R1,0,R0,0, 0,1,1,0), 120);           // R1=1
    apply(mk(1,0,R0,0,R0,1,R1,0,R0,0, 0,1,1,0), 121);           // R1=2
    apply(mk(1,1,R1,0,R0,0,R0,1,R1,0, 1,0,1,0), 122);           // R1=1
    apply(mk(0,0,R0,0,R0,0,R0,1,R1,0, 0,0,0,0), 123);           // R1=0

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
